// File: rtl/regfile_sb.sv
// Register file with a per-register busy scoreboard, two combinational read ports,
// and optional same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  iss_valid,
    input  logic [ADDR_WIDTH-1:0] iss_rd,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic                  rbusy1,
    output logic                  rbusy2,
    output logic [ADDR_WIDTH:0]   busy_cnt
);

    localparam int unsigned       DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_rf [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [ADDR_WIDTH:0]   r_busy_cnt;

    logic                  w_wr;
    logic                  w_iss;
    logic                  w_inc;
    logic                  w_dec;
    logic [DEPTH-1:0]      w_busy_next;
    logic                  w_hit1;
    logic                  w_hit2;

    // Issue is applied after writeback so a new producer keeps the bit set.
    always_comb begin
        w_wr        = wen && (waddr != '0);
        w_iss       = iss_valid && (iss_rd != '0);
        w_busy_next = r_busy;
        if (w_wr) begin
            w_busy_next[waddr] = 1'b0;
        end
        if (w_iss) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_inc = w_iss && !r_busy[iss_rd];
        w_dec = w_wr && r_busy[waddr] && !(w_iss && (iss_rd == waddr));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_rf[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_rf[waddr] <= wdata;
            end
            r_busy <= w_busy_next;
            case ({w_inc, w_dec})
                2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
                2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
                default: r_busy_cnt <= r_busy_cnt;
            endcase
        end
    end

    always_comb begin
        w_hit1 = BYPASS && wen && (waddr == raddr1) && (raddr1 != '0);
        w_hit2 = BYPASS && wen && (waddr == raddr2) && (raddr2 != '0);

        rdata1 = '0;
        if (raddr1 != '0) begin
            rdata1 = w_hit1 ? wdata : r_rf[raddr1];
        end
        rdata2 = '0;
        if (raddr2 != '0) begin
            rdata2 = w_hit2 ? wdata : r_rf[raddr2];
        end

        rbusy1   = r_busy[raddr1] && !w_hit1;
        rbusy2   = r_busy[raddr2] && !w_hit2;
        busy_cnt = r_busy_cnt;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized bench for regfile_sb: forwarding and non-forwarding instances share stimulus
// and are checked against an array-based model of registers and busy bits.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;

    logic [31:0] rdata1_b, rdata2_b, rdata1_n, rdata2_n;
    logic        rbusy1_b, rbusy2_b, rbusy1_n, rbusy2_n;
    logic [5:0]  busy_cnt_b, busy_cnt_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_rf [32];
    bit          m_busy [32];

    always #5 clk = ~clk;

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_b), .rdata2(rdata2_b), .rbusy1(rbusy1_b), .rbusy2(rbusy2_b),
        .busy_cnt(busy_cnt_b)
    );

    regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rdata1_n), .rdata2(rdata2_n), .rbusy1(rbusy1_n), .rbusy2(rbusy2_n),
        .busy_cnt(busy_cnt_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] ra, input bit fwd);
        if (ra == 5'd0) return 32'd0;
        if (fwd && !rst && wen && waddr == ra) return wdata;
        if (fwd && rst && wen && waddr == ra) return wdata;
        return m_rf[ra];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] ra, input bit fwd);
        bit b;
        b = m_busy[ra] && !(fwd && wen && waddr == ra);
        return {31'd0, b};
    endfunction

    function automatic logic [31:0] model_popcount();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return 32'(c);
    endfunction

    // Drive one cycle's inputs away from the active edge and compare every output.
    task automatic drive_check(input logic t_rst, input logic t_wen, input logic [4:0] t_waddr,
                               input logic [31:0] t_wdata, input logic t_iv,
                               input logic [4:0] t_rd, input logic [4:0] t_ra1,
                               input logic [4:0] t_ra2);
        @(negedge clk);
        rst = t_rst; wen = t_wen; waddr = t_waddr; wdata = t_wdata;
        iss_valid = t_iv; iss_rd = t_rd; raddr1 = t_ra1; raddr2 = t_ra2;
        #1;
        check("rdata1_byp", rdata1_b, exp_data(t_ra1, 1'b1));
        check("rdata2_byp", rdata2_b, exp_data(t_ra2, 1'b1));
        check("rbusy1_byp", {31'd0, rbusy1_b}, exp_busy(t_ra1, 1'b1));
        check("rbusy2_byp", {31'd0, rbusy2_b}, exp_busy(t_ra2, 1'b1));
        check("cnt_byp", {26'd0, busy_cnt_b}, model_popcount());
        check("rdata1_nob", rdata1_n, exp_data(t_ra1, 1'b0));
        check("rdata2_nob", rdata2_n, exp_data(t_ra2, 1'b0));
        check("rbusy1_nob", {31'd0, rbusy1_n}, exp_busy(t_ra1, 1'b0));
        check("rbusy2_nob", {31'd0, rbusy2_n}, exp_busy(t_ra2, 1'b0));
        check("cnt_nob", {26'd0, busy_cnt_n}, model_popcount());
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_rf[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
        end else begin
            if (wen && waddr != 5'd0) begin
                m_rf[waddr] = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (iss_valid && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        end
    endtask

    task automatic cyc(input logic t_rst, input logic t_wen, input logic [4:0] t_waddr,
                       input logic [31:0] t_wdata, input logic t_iv, input logic [4:0] t_rd,
                       input logic [4:0] t_ra1, input logic [4:0] t_ra2);
        drive_check(t_rst, t_wen, t_waddr, t_wdata, t_iv, t_rd, t_ra1, t_ra2);
        tick();
    endtask

    initial begin
        logic [4:0] wa, ra1, ra2;
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = 32'hxxxx_xxxx;
            m_busy[i] = 1'b0;
        end
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_rd = '0; raddr1 = '0; raddr2 = '0;
        @(negedge clk);
        tick();

        // Reset state on every index.
        for (int i = 0; i < 32; i += 2) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(i + 1));

        // Same-cycle forwarding versus next-cycle visibility.
        drive_check(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5);
        check("fwd_byp", rdata1_b, 32'hDEADBEEF);
        check("fwd_nob", rdata1_n, 32'd0);
        tick();
        drive_check(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        check("next_nob", rdata1_n, 32'hDEADBEEF);
        tick();

        // Index 0 is hardwired zero for writes and issues.
        cyc(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        drive_check(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        check("x0_data", rdata1_b, 32'd0);
        check("x0_cnt", {26'd0, busy_cnt_b}, 32'd0);
        tick();

        // Issue 3 and 7, then write back 3.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd7);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd3, 5'd7);
        drive_check(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd7);
        check("two_busy_cnt", {26'd0, busy_cnt_b}, 32'd2);
        check("busy3", {31'd0, rbusy1_b}, 32'd1);
        check("busy7", {31'd0, rbusy2_n}, 32'd1);
        tick();
        drive_check(1'b0, 1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 5'd3, 5'd3);
        check("wb3_byp_busy", {31'd0, rbusy1_b}, 32'd0);
        check("wb3_byp_data", rdata1_b, 32'h55);
        check("wb3_nob_busy", {31'd0, rbusy1_n}, 32'd1);
        tick();
        drive_check(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd7);
        check("one_busy_cnt", {26'd0, busy_cnt_n}, 32'd1);
        check("wb3_nob_data", rdata1_n, 32'h55);
        tick();

        // Simultaneous issue and writeback to a busy register.
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        cyc(1'b0, 1'b1, 5'd9, 32'hA5, 1'b1, 5'd9, 5'd9, 5'd0);
        drive_check(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9);
        check("waw_busy", {31'd0, rbusy1_b}, 32'd1);
        check("waw_data", rdata1_n, 32'hA5);
        check("waw_cnt", {26'd0, busy_cnt_b}, 32'd2);
        tick();

        // Randomized traffic, occasionally reading the write target.
        for (int n = 0; n < 3000; n++) begin
            wa  = 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)), wa, $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), ra1, ra2);
        end

        // Fill the scoreboard, then reset with a competing write.
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        for (int i = 1; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'(i), 5'd0);
        drive_check(1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 1'b1, 5'd6, 5'd4, 5'd31);
        check("peak_cnt", {26'd0, busy_cnt_b}, 32'd31);
        tick();
        drive_check(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd6);
        check("rst_cnt", {26'd0, busy_cnt_n}, 32'd0);
        check("rst_blocked_wr", rdata1_b, 32'd0);
        check("rst_busy6", {31'd0, rbusy2_b}, 32'd0);
        tick();
        for (int i = 0; i < 32; i += 2) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'(i), 5'(i + 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
